fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 11 +
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch datapath and the control FSM.
// It holds the fetch state encodings, the major opcode values and the data width.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] FETCH_IDLE = 2'b00;
  localparam logic [1:0] FETCH_REQ  = 2'b01;
  localparam logic [1:0] FETCH_ERR  = 2'b10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port: the fetch unit is master.
// The master holds mem_req and mem_addr until the slave returns a one-cycle mem_ack.
interface fetch_unit_if;
  logic                          mem_req;
  logic [riscv_pkg::XLEN-1:0]    mem_addr;
  logic [riscv_pkg::XLEN-1:0]    mem_rdata;
  logic                          mem_ack;

  modport master (output mem_req, mem_addr, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: it owns the PC and the instruction register, and it runs one memory read per irwrite.
// The sticky error state is entered on a fetch timeout or on a misaligned PC write. Only reset clears it.
//   state      | meaning
//   FETCH_IDLE | no fetch outstanding, accepts irwrite
//   FETCH_REQ  | read outstanding, waiting for mem_ack
//   FETCH_ERR  | timeout or misaligned PC write, held until reset
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]      TIMEOUT  = 8'd255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            irwrite,
  input  logic            pcupdate,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] result,
  fetch_unit_if.master    mem,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] oldpc,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic            instr_valid,
  output logic            stall,
  output logic            err
);

  logic [1:0]      state;
  logic [7:0]      wait_cnt;
  logic [XLEN-1:0] addr;
  logic            pc_we;
  logic            pc_bad;
  logic            wait_last;

  assign pc_we     = (pcupdate | (branch & zero)) && (state != FETCH_ERR);
  assign pc_bad    = pc_we && !word_aligned(result);
  // 9-bit compare so that a TIMEOUT of 0 cannot wrap the counter.
  assign wait_last = ({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH_IDLE;
      pc          <= RESET_PC;
      oldpc       <= '0;
      instr       <= '0;
      addr        <= '0;
      instr_valid <= 1'b0;
      err         <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (pc_we && !pc_bad) pc <= result;

      case (state)
        FETCH_IDLE: begin
          if (irwrite) begin
            addr        <= pc;
            oldpc       <= pc;
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= FETCH_REQ;
          end
        end
        FETCH_REQ: begin
          if (mem.mem_ack) begin
            instr       <= mem.mem_rdata;
            instr_valid <= 1'b1;
            state       <= FETCH_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_last) begin
              state <= FETCH_ERR;
              err   <= 1'b1;
            end
          end
        end
        FETCH_ERR: ;
        default:   state <= FETCH_ERR;
      endcase

      // A misaligned PC write overrides whatever the fetch sequence chose.
      if (pc_bad) begin
        state       <= FETCH_ERR;
        err         <= 1'b1;
        instr_valid <= 1'b0;
      end
    end
  end

  assign mem.mem_req  = (state == FETCH_REQ);
  assign mem.mem_addr = addr;
  assign stall        = (state != FETCH_IDLE);
  assign op           = instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard checks every memory request and every completed fetch.
// Direct checks cover PC updates, the error state and reset behaviour.
module tb_fetch_unit;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] oldpc;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irwrite = 1'b0, pcupdate = 1'b0, branch = 1'b0, zero = 1'b0;
  logic [31:0] result = '0;
  logic [31:0] pc, oldpc, instr;
  logic [6:0]  op;
  logic        instr_valid, stall, err;

  fetch_unit_if mem_bus();

  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset), .irwrite(irwrite), .pcupdate(pcupdate),
    .branch(branch), .zero(zero), .result(result), .mem(mem_bus),
    .pc(pc), .oldpc(oldpc), .instr(instr), .op(op),
    .instr_valid(instr_valid), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_addr_q[$];
  fetch_t      exp_fetch_q[$];
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the start of each memory request and each new valid instruction pops one expected entry.
  always @(negedge clk) begin
    if (mem_bus.mem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_req: got addr %h, expected no request", mem_bus.mem_addr);
      end else begin
        chk("req_addr", mem_bus.mem_addr, exp_addr_q.pop_front());
      end
    end
    if (instr_valid && !prev_valid) begin
      if (exp_fetch_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_fetch: got instr %h, expected none", instr);
      end else begin
        fetch_t e;
        e = exp_fetch_q.pop_front();
        chk("fetch_instr", instr, e.instr);
        chk("fetch_op", {25'd0, op}, {25'd0, e.op});
        chk("fetch_oldpc", oldpc, e.oldpc);
      end
    end
    prev_req   = mem_bus.mem_req;
    prev_valid = instr_valid;
  end

  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                       input logic [6:0] exp_op, input int waits);
    int st;
    st = 0;
    exp_addr_q.push_back(exp_addr);
    exp_fetch_q.push_back('{rdata, exp_op, exp_addr});
    irwrite = 1'b1; tick(); irwrite = 1'b0;
    for (int i = 0; i < waits; i++) begin
      if (stall) st++;
      tick();
    end
    if (stall) st++;
    mem_bus.mem_rdata = rdata; mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'hA5A5_5A5A;
    chk("stall_cycles", st, waits + 1);
    chk("stall_after_ack", {31'd0, stall}, 32'd0);
    chk("err_after_fetch", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_oldpc", oldpc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_op", {25'd0, op}, 32'h0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_flags", {28'd0, mem_bus.mem_req, stall, instr_valid, err}, 32'h0);
    reset = 1'b1;

    // First fetch after reset release: two wait cycles, then an addi.
    fetch(32'h0, 32'h0000_0013, 7'b0010011, 2);
    chk("valid_after_fetch", {31'd0, instr_valid}, 32'd1);

    // Fetch and PC update in the same cycle, then a PC write during REQ.
    pcupdate = 1'b1; result = 32'h100; tick(); pcupdate = 1'b0;
    chk("pc_set_100", pc, 32'h100);
    exp_addr_q.push_back(32'h100);
    exp_fetch_q.push_back('{32'h0000_006F, 7'h6F, 32'h100});
    irwrite = 1'b1; pcupdate = 1'b1; result = 32'h104; tick();
    irwrite = 1'b0;
    chk("pc_same_cycle", pc, 32'h104);
    chk("oldpc_same_cycle", oldpc, 32'h100);
    chk("valid_cleared", {31'd0, instr_valid}, 32'd0);
    result = 32'h108; tick(); pcupdate = 1'b0;
    chk("pc_in_req", pc, 32'h108);
    chk("addr_held", mem_bus.mem_addr, 32'h100);
    mem_bus.mem_rdata = 32'h0000_006F; mem_bus.mem_ack = 1'b1; tick(); mem_bus.mem_ack = 1'b0;

    // Branch is qualified by zero.
    branch = 1'b1; zero = 1'b0; result = 32'h200; tick();
    chk("branch_not_taken", pc, 32'h108);
    zero = 1'b1; tick(); branch = 1'b0; zero = 1'b0;
    chk("branch_taken", pc, 32'h200);

    // Ack in the last allowed REQ cycle is still accepted.
    fetch(32'h200, 32'h1234_50B7, 7'h37, 3);

    // Ack outside REQ is ignored.
    mem_bus.mem_rdata = 32'hDEAD_BEEF; mem_bus.mem_ack = 1'b1; tick(); mem_bus.mem_ack = 1'b0;
    chk("stray_ack_instr", instr, 32'h1234_50B7);
    chk("stray_ack_state", {30'd0, stall, instr_valid}, 32'd1);

    // Timeout: no ack for 4 wait cycles.
    exp_addr_q.push_back(32'h200);
    irwrite = 1'b1; tick(); irwrite = 1'b0;
    tick(); tick(); tick();
    chk("no_err_before_timeout", {31'd0, err}, 32'd0);
    tick();
    chk("err_at_timeout", {31'd0, err}, 32'd1);
    chk("err_state_outputs", {29'd0, mem_bus.mem_req, stall, instr_valid}, 32'b010);
    irwrite = 1'b1; tick(); irwrite = 1'b0;
    mem_bus.mem_ack = 1'b1; tick(); mem_bus.mem_ack = 1'b0;
    pcupdate = 1'b1; result = 32'h300; tick(); pcupdate = 1'b0;
    chk("err_ignores_all", {29'd0, mem_bus.mem_req, stall, instr_valid}, 32'b010);
    chk("err_pc_frozen", pc, 32'h200);
    chk("err_instr_frozen", instr, 32'h1234_50B7);

    // Misaligned PC write.
    reset = 1'b0; tick(); reset = 1'b1;
    chk("reset_clears_err", {30'd0, err, stall}, 32'd0);
    pcupdate = 1'b1; result = 32'h102; tick(); pcupdate = 1'b0;
    chk("misaligned_pc", pc, 32'h0);
    chk("misaligned_err", {30'd0, err, stall}, 32'b11);

    // Reset in the middle of a fetch, followed by a late ack.
    reset = 1'b0; tick(); reset = 1'b1;
    exp_addr_q.push_back(32'h0);
    irwrite = 1'b1; tick(); irwrite = 1'b0;
    tick();
    chk("req_before_reset", {31'd0, mem_bus.mem_req}, 32'd1);
    reset = 1'b0; #1;
    chk("req_dropped_async", {31'd0, mem_bus.mem_req}, 32'd0);
    tick(); reset = 1'b1;
    mem_bus.mem_rdata = 32'hFFFF_FFFF; mem_bus.mem_ack = 1'b1; tick(); mem_bus.mem_ack = 1'b0;
    chk("late_ack_flags", {29'd0, mem_bus.mem_req, instr_valid, stall}, 32'd0);
    chk("late_ack_instr", instr, 32'h0);

    tick();
    chk("addr_q_drained", exp_addr_q.size(), 32'd0);
    chk("fetch_q_drained", exp_fetch_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
